// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the wait-state APB slave memory.
//   state_t      : access FSM states
//   CNT_W        : wait counter width (supports WAIT_STATES 0..15)
//   strb_width() : byte lanes per data word
//   addr_lsb()   : byte-offset bits below the word index
package apb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_slave_mem_ws_if.sv
// APB3-style bus bundle between the master/interconnect and the slave memory.
//   mem_selx, mem_valid, mem_wr_rd, mem_addr, mem_wdata, mem_strb : master -> slave
//   mem_rdata, mem_ready, mem_slverr                              : slave -> master
interface apb_slave_mem_ws_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                      mem_selx;
  logic                      mem_valid;
  logic                      mem_wr_rd;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_strb;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_ready;
  logic                      mem_slverr;

  modport master (
    output mem_selx, mem_valid, mem_wr_rd, mem_addr, mem_wdata, mem_strb,
    input  mem_rdata, mem_ready, mem_slverr
  );

  modport slave (
    input  mem_selx, mem_valid, mem_wr_rd, mem_addr, mem_wdata, mem_strb,
    output mem_rdata, mem_ready, mem_slverr
  );
endinterface

// File: rtl/apb_mem_addr_chk.sv
// Combinational address decode for the slave memory.
//   addr     : byte address
//   wr_rd    : 1 = write (only matters for the write-protect check)
//   word_idx : word index, truncated to the memory's index width
//   err      : out of range, misaligned, or (APB_MEM_WR_PROTECT_EN) a write
//              into the read-only word range [RO_BASE, RO_LIMIT]
module apb_mem_addr_chk
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RO_BASE    = 240,
  parameter int RO_LIMIT   = 255,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  err
);

  localparam int ADDR_LSB   = addr_lsb(DATA_WIDTH);
  localparam int IDX_FULL_W = ADDR_WIDTH - ADDR_LSB;

  logic [IDX_FULL_W-1:0] idx_full;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  protected_wr;

  assign idx_full     = addr[ADDR_WIDTH-1:ADDR_LSB];
  assign out_of_range = 32'(idx_full) >= 32'(DEPTH);
  // Only meaningful when err is low, so the truncated bits are in range then.
  assign word_idx     = idx_full[IDX_W-1:0];

  generate
    if (ADDR_LSB > 0) begin : g_align
      assign misaligned = |addr[ADDR_LSB-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

`ifdef APB_MEM_WR_PROTECT_EN
  assign protected_wr = wr_rd && (32'(idx_full) >= 32'(RO_BASE))
                              && (32'(idx_full) <= 32'(RO_LIMIT));
`else
  // Region is writable in this build; keep the inputs referenced.
  logic unused_prot;
  assign unused_prot  = wr_rd ^ (RO_BASE > RO_LIMIT);
  assign protected_wr = 1'b0;
`endif

  assign err = out_of_range || misaligned || protected_wr;

endmodule

// File: rtl/apb_slave_mem_ws.sv
// APB3-style slave memory with programmable wait states, byte strobes and
// error response. Optional build macro: APB_MEM_WR_PROTECT_EN (writes into
// word range [RO_BASE, RO_LIMIT] answer with slverr and are dropped).
//   mem_clk   : clock, all logic on rising edge
//   mem_rst_n : synchronous active-low reset; clears outputs, FSM and memory
//   bus       : apb_slave_mem_ws_if.slave (psel/penable/pwrite/paddr/pwdata/
//               pstrb in; registered prdata/pready/pslverr out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in progress; waiting for selx && valid
// ST_WAIT | access phase, counting down inserted wait states
// ST_RESP | ready/slverr/rdata presented for exactly one cycle
module apb_slave_mem_ws
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int RO_BASE     = 240,
  parameter int RO_LIMIT    = 255
) (
  input logic               mem_clk,
  input logic               mem_rst_n,
  apb_slave_mem_ws_if.slave bus
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   complete;
  logic                   access;

  logic [IDX_W-1:0]       word_idx;
  logic                   addr_err;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   ready_q;
  logic                   slverr_q;

  apb_mem_addr_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .RO_BASE    (RO_BASE),
    .RO_LIMIT   (RO_LIMIT),
    .IDX_W      (IDX_W)
  ) u_addr_chk (
    .addr     (bus.mem_addr),
    .wr_rd    (bus.mem_wr_rd),
    .word_idx (word_idx),
    .err      (addr_err)
  );

  assign access = bus.mem_selx && bus.mem_valid;

  always_ff @(posedge mem_clk) begin
    if (!mem_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
            state_d  = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Master withdrew the transfer: drop it silently.
        if (!access) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers default to zero every cycle, so they are only
  // non-zero in the single cycle following a completing edge.
  always_ff @(posedge mem_clk) begin
    if (!mem_rst_n) begin
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rdata_q  <= '0;
      ready_q  <= complete;
      slverr_q <= complete && addr_err;
      if (complete && !addr_err) begin
        if (bus.mem_wr_rd) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (bus.mem_strb[b]) begin
              mem[word_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
          end
        end else begin
          rdata_q <= mem[word_idx];
        end
      end
    end
  end

  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_ready  = ready_q;
  assign bus.mem_slverr = slverr_q;

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Self-checking bench for apb_slave_mem_ws: directed vector table, abort and
// reset sequences, then randomized transfers against a word-array model.
module tb_apb_slave_mem_ws;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int RO_B  = 240;
  localparam int RO_L  = 255;
`ifdef APB_MEM_WR_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_slave_mem_ws_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave_mem_ws #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH),
    .WAIT_STATES(WS), .RO_BASE (RO_B), .RO_LIMIT (RO_L)
  ) dut (
    .mem_clk   (clk),
    .mem_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endfunction

  // Word-level behaviour of one completed transfer.
  function automatic void model_xfer(input bit wr, input logic [11:0] addr,
                                     input logic [31:0] wd, input logic [3:0] st,
                                     output logic [31:0] rd, output bit err);
    int idx;
    idx = int'(addr) / 4;
    err = (idx >= DEPTH) || (int'(addr) % 4 != 0) ||
          (PROT && wr && idx >= RO_B && idx <= RO_L);
    rd = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = ref_mem[idx];
      end
    end
  endfunction

  task automatic idle_bus();
    bus.mem_selx  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_wr_rd = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_strb  = '0;
  endtask

  // Setup phase, access phase, wait for ready (bounded), then check the drop.
  task automatic do_xfer(input string name, input bit wr, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output logic [31:0] rd, output bit err, output int lat);
    int  edges;
    bit  ok;
    edges = 0;
    ok    = 1'b0;
    rd    = 32'h0;
    err   = 1'b0;
    @(negedge clk);
    bus.mem_selx  = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wr_rd = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    bus.mem_strb  = st;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    while (edges < 40 && !ok) begin
      @(negedge clk);
      edges++;
      if (bus.mem_ready) ok = 1'b1;
      else check({name, "_wait_zero"}, bus.mem_rdata | {31'h0, bus.mem_slverr}, 32'h0);
    end
    lat = edges - 1;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
    end else begin
      rd  = bus.mem_rdata;
      err = bus.mem_slverr;
    end
    bus.mem_selx  = 1'b0;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check({name, "_ready_drop"}, {31'h0, bus.mem_ready}, 32'h0);
    check({name, "_resp_clear"}, bus.mem_rdata | {31'h0, bus.mem_slverr}, 32'h0);
  endtask

  task automatic run_one(input string name, input bit wr, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    bit          err;
    int          lat;
    do_xfer(name, wr, addr, wd, st, rd, err, lat);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_slverr"}, {31'h0, err}, {31'h0, exp_err});
    check({name, "_latency"}, 32'(lat), 32'(WS));
  endtask

  initial begin
    logic [31:0] m_rd;
    bit          m_err;

    vecs[0]  = '{1'b0, 12'h010, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 12'h020, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 12'h020, 32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 12'h020, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 12'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 12'h021, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 12'h021, 32'h99999999, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 12'h020, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[8]  = '{1'b1, 12'h030, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 12'h030, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 12'h030, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 12'h3C0, 32'h12345678, 4'hF, 32'h0,        PROT};
    vecs[12] = '{1'b0, 12'h3C0, 32'h0,        4'h0, PROT ? 32'h0 : 32'h12345678, 1'b0};
    vecs[13] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 12'hFFC, 32'h0BADF00D, 4'hF, 32'h0,        1'b1};

    idle_bus();
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("reset_rdata", bus.mem_rdata, 32'h0);
    check("reset_slverr", {31'h0, bus.mem_slverr}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st, m_rd, m_err);
      run_one($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd,
              vecs[i].st, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Abort: valid drops after one access edge of a write to 0x030.
    @(negedge clk);
    bus.mem_selx  = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wr_rd = 1'b1;
    bus.mem_addr  = 12'h030;
    bus.mem_wdata = 32'h0BADBAD0;
    bus.mem_strb  = 4'hF;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_selx  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_ready", {31'h0, bus.mem_ready}, 32'h0);
    end
    run_one("abort_readback", 1'b0, 12'h030, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    // Reset in the middle of a write's wait phase.
    model_xfer(1'b1, 12'h040, 32'h55AA55AA, 4'hF, m_rd, m_err);
    run_one("pre_reset_wr", 1'b1, 12'h040, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    bus.mem_selx  = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wr_rd = 1'b1;
    bus.mem_addr  = 12'h040;
    bus.mem_wdata = 32'hFFFFFFFF;
    bus.mem_strb  = 4'hF;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("midrst_out", bus.mem_rdata | {31'h0, bus.mem_slverr}, 32'h0);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    run_one("post_reset_040", 1'b0, 12'h040, 32'h0, 4'h0, 32'h0, 1'b0);
    run_one("post_reset_020", 1'b0, 12'h020, 32'h0, 4'h0, 32'h0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      int          sel;
      int          idx;
      logic [11:0] addr;
      bit          wr;
      logic [31:0] wd;
      logic [3:0]  st;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      idx = int'($urandom_range(0, 15));
      else if (sel < 8) idx = int'($urandom_range(236, 255));
      else              idx = int'($urandom_range(256, 1023));
      addr = 12'(idx * 4);
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      model_xfer(wr, addr, wd, st, m_rd, m_err);
      run_one($sformatf("rnd%0d", i), wr, addr, wd, st, m_rd, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem_ws.md
Name: apb_slave_mem_ws

Overview:
- Parametrised APB3-style slave memory with programmable wait states, byte write strobes and error response.
- Sits behind the APB master/interconnect in the UVM bench as the DUT slave.
- Successor of the zero-wait, full-address-space slave: bounded depth, address decode errors, a proper access FSM.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 12, byte address width.
- DEPTH, 256, number of DATA_WIDTH words; DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
- WAIT_STATES, 2, access-phase cycles inserted before mem_ready; 0..15.
- RO_BASE, 240, first word index of the read-only region (used only with the optional feature).
- RO_LIMIT, 255, last word index of the read-only region, inclusive.

Ports:
- mem_clk  in  1  system clock; all logic on rising edge.
- mem_rst_n  in  1  reset, synchronous, active-low.
- mem_selx  in  1  psel.
- mem_valid  in  1  penable.
- mem_wr_rd  in  1  pwrite; 1=write, 0=read.
- mem_addr  in  ADDR_WIDTH  paddr, byte address.
- mem_wdata  in  DATA_WIDTH  pwdata.
- mem_strb  in  DATA_WIDTH/8  pstrb; byte write enables.
- mem_rdata  out  DATA_WIDTH  prdata, registered.
- mem_ready  out  1  pready, registered.
- mem_slverr  out  1  pslverr, registered.

Behaviour:
- Reset (mem_rst_n=0 at an edge):
  - mem_rdata=0, mem_ready=0, mem_slverr=0.
  - FSM=IDLE, wait counter=0, all memory words cleared to 0.
  - Reset overrides any in-flight transfer; no write commits.
- Addressing:
  - ADDR_LSB=log2(DATA_WIDTH/8); word index idx=mem_addr>>ADDR_LSB.
  - Error if idx>=DEPTH or mem_addr[ADDR_LSB-1:0]!=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with selx&&valid: if WAIT_STATES==0, complete at this edge and go to RESP.
  - Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If selx or valid is low at an edge: abort, go to IDLE; no write, ready stays 0.
  - Else if cnt==0: complete and go to RESP.
  - Else cnt decrements.
- Complete (at that edge):
  - mem_ready=1.
  - Write without error: each byte b with mem_strb[b]=1 is updated; other bytes are unchanged.
  - Read without error: mem_rdata=mem[idx].
  - On error: no write, mem_rdata=0, mem_slverr=1.
- RESP:
  - Ready is high for exactly one cycle.
  - Next edge: mem_ready=0, mem_slverr=0, mem_rdata=0, go to IDLE. Back-to-back access needs a new setup phase.
- Latency: mem_ready rises WAIT_STATES edges after the first edge sampling selx&&valid in IDLE.
- Address, data, strobe and direction are sampled at the completing edge; the master holds them stable per APB.
- mem_rdata and mem_slverr are 0 in every cycle where mem_ready=0.
- A write with mem_strb=0 completes with ready and no error, and changes no data.

Optional Feature:
- Macro: APB_MEM_WR_PROTECT_EN.
- Defined: a write whose idx lies in [RO_BASE,RO_LIMIT] completes with mem_slverr=1 and no write; reads of that region behave normally.
- Undefined: RO_BASE and RO_LIMIT are ignored; the region is writable.

Decomposition:
- Package apb_mem_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - Helpers for localparams STRB_WIDTH=DATA_WIDTH/8 and ADDR_LSB, derived from DATA_WIDTH.
  - Counter width constant (4 bits).
- One natural sub-module: apb_mem_addr_chk.
  - Combinational decode of idx and the error flag, including the protect check under the macro.
  - Instantiated once.

Test Plan:
- Reset, then read addr 0x010 with WAIT_STATES=2 -> ready high exactly 2 edges after access start, rdata=0x0, slverr=0; ready low next cycle.
- Write 0xDEADBEEF to 0x020 with strb=0xF, then write 0x11223344 with strb=0x5 -> read 0x020 returns 0xDE22BE44.
- Read addr 0x400 (idx 256, DEPTH=256) and read 0x021 (misaligned) -> ready with slverr=1 and rdata=0; memory unchanged.
- Drop valid during WAIT after 1 cycle of a write to 0x030 -> no ready pulse; a later read of 0x030 returns the old value.
- Assert reset during WAIT of a write to 0x040 -> outputs 0 at the next edge; read 0x040 after reset returns 0.
- With APB_MEM_WR_PROTECT_EN: write 0x3C0 (idx 240) -> slverr=1 and the read returns the old data. Without the macro -> write succeeds.
